// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity link (transmitter and checker).
// Holds the FSM state encoding and the parity-mode constants.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Parity mode: value XORed into the payload parity to form the frame bit.
    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    // Bit counter width; covers payloads up to 32 bits plus the terminal count.
    localparam int BITCNT_W = 6;

endpackage

// File: rtl/parity_tx_shifter.sv
// Load/shift datapath for parity_tx.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture load_data, clear bit counter and parity accumulator
//   shift        shift right one bit, fold the outgoing bit into the parity
//   load_data    parallel word to capture
//   bit0         current LSB of the shift register (bit on the line)
//   acc          running parity of bits already shifted out
//   last_bit     the bit now at bit0 is the final payload bit
module parity_tx_shifter
    import parity_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] load_data,
    output logic              bit0,
    output logic              acc,
    output logic              last_bit
);

    logic [DATA_W-1:0]   shreg;
    logic [BITCNT_W-1:0] bitcnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours (acc folds the old shreg[0]).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            bitcnt <= '0;
            acc    <= 1'b0;
        end else if (load) begin
            shreg  <= load_data;
            bitcnt <= '0;
            acc    <= 1'b0;
        end else if (shift) begin
            shreg  <= shreg >> 1;
            bitcnt <= bitcnt + 1'b1;
            acc    <= acc ^ shreg[0];
        end
    end

    assign bit0     = shreg[0];
    assign last_bit = (bitcnt == BITCNT_W'(DATA_W - 1));

endmodule

// File: rtl/parity_tx.sv
// Serial parity transmitter: accepts a word over valid/ready, sends it
// LSB-first one bit per clock, then appends one parity bit.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_data      parallel word to send
//   in_valid     in_data valid, held until accepted
//   in_ready     a word can be accepted this cycle (IDLE or PARITY)
//   tx           serial payload/parity bit
//   tx_valid     tx carries a frame bit
//   tx_last      tx carries the parity bit
//   ev           parity of payload bits already sent in this frame
//   frame_cnt    completed frames, wraps modulo 2^CNT_W
module parity_tx
    import parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              tx_valid,
    output logic              tx_last,
    output logic              ev,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam logic PAR_MODE = (ODD_PARITY != 0) ? ODD : EVEN;

    state_t state_q, state_d;
    logic   load, shift, accept;
    logic   bit0, acc, last_bit;

    parity_tx_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .shift     (shift),
        .load_data (in_data),
        .bit0      (bit0),
        .acc       (acc),
        .last_bit  (last_bit)
    );

    // Ready decodes registered state only; held low while in reset.
    assign in_ready = rst_n && ((state_q == IDLE) || (state_q == PARITY));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                shift = 1'b1;
                if (last_bit) state_d = PARITY;
            end
            PARITY: begin
                // Accepting here gives back-to-back frames with no gap.
                if (accept) begin
                    load    = 1'b1;
                    state_d = DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx       = 1'b0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        case (state_q)
            DATA: begin
                tx       = bit0;
                tx_valid = 1'b1;
            end
            PARITY: begin
                tx       = acc ^ PAR_MODE;
                tx_valid = 1'b1;
                tx_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign ev = acc;

    // A frame completes on the edge that leaves PARITY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 frame_cnt <= '0;
        else if (state_q == PARITY) frame_cnt <= frame_cnt + 1'b1;
    end

endmodule

// File: tb/tb_parity_tx.sv
// Directed bench for parity_tx: three instances cover even/8-bit, odd/8-bit
// and even/1-bit with a 2-bit frame counter. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_parity_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  e8_data = '0, o8_data = '0;
    logic        e8_valid = 1'b0, o8_valid = 1'b0;
    logic        e8_ready, e8_tx, e8_txv, e8_last, e8_ev;
    logic        o8_ready, o8_tx, o8_txv, o8_last, o8_ev;
    logic [15:0] e8_cnt, o8_cnt;

    logic [0:0]  e1_data = '0;
    logic        e1_valid = 1'b0;
    logic        e1_ready, e1_tx, e1_txv, e1_last, e1_ev;
    logic [1:0]  e1_cnt;

    parity_tx #(.DATA_W(8), .ODD_PARITY(0), .CNT_W(16)) u_e8 (
        .clk(clk), .rst_n(rst_n), .in_data(e8_data), .in_valid(e8_valid),
        .in_ready(e8_ready), .tx(e8_tx), .tx_valid(e8_txv), .tx_last(e8_last),
        .ev(e8_ev), .frame_cnt(e8_cnt)
    );

    parity_tx #(.DATA_W(8), .ODD_PARITY(1), .CNT_W(16)) u_o8 (
        .clk(clk), .rst_n(rst_n), .in_data(o8_data), .in_valid(o8_valid),
        .in_ready(o8_ready), .tx(o8_tx), .tx_valid(o8_txv), .tx_last(o8_last),
        .ev(o8_ev), .frame_cnt(o8_cnt)
    );

    parity_tx #(.DATA_W(1), .ODD_PARITY(0), .CNT_W(2)) u_e1 (
        .clk(clk), .rst_n(rst_n), .in_data(e1_data), .in_valid(e1_valid),
        .in_ready(e1_ready), .tx(e1_tx), .tx_valid(e1_txv), .tx_last(e1_last),
        .ev(e1_ev), .frame_cnt(e1_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        e8_valid = 1'b0;
        o8_valid = 1'b0;
        e1_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] w;
        logic [1:0] cnt_exp [5];
        logic       e1_words [5];
        int         vcnt;

        // ---- Reset then idle ----
        repeat (3) tick();
        check("rst_txv", e8_txv, 1'b0);
        check("rst_tx", e8_tx, 1'b0);
        check("rst_cnt", e8_cnt, 16'd0);
        check("rst_ready", e8_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        check("rel_ready", e8_ready, 1'b1);

        // ---- Even parity, 0xA5: payload 1,0,1,0,0,1,0,1 then parity 0 ----
        w = 8'hA5;
        e8_data  = w;
        e8_valid = 1'b1;
        tick();
        e8_valid = 1'b0;
        e8_data  = 8'h3C; // ignored after accept
        check("a5_ev_first", e8_ev, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("a5_bit%0d", i), e8_tx, w[i]);
            check($sformatf("a5_v%0d", i), {e8_txv, e8_last, e8_ready}, 3'b100);
            tick();
        end
        check("a5_par", e8_tx, 1'b0);
        check("a5_par_flags", {e8_txv, e8_last, e8_ready}, 3'b111);
        check("a5_par_ev", e8_ev, 1'b0);
        tick();
        check("a5_idle_txv", e8_txv, 1'b0);
        check("a5_cnt", e8_cnt, 16'd1);

        // ---- Odd parity, 0x07: payload 1,1,1,0,0,0,0,0 then parity 0 ----
        w = 8'h07;
        o8_data  = w;
        o8_valid = 1'b1;
        tick();
        o8_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("o07_bit%0d", i), o8_tx, w[i]);
            tick();
        end
        check("o07_par", o8_tx, 1'b0);
        check("o07_last", o8_last, 1'b1);
        check("o07_ev", o8_ev, 1'b1);
        tick();
        check("o07_cnt", o8_cnt, 16'd1);

        // ---- Back-to-back 0x07 then 0x00, even: parity 1 then 0 ----
        do_reset();
        w = 8'h07;
        e8_data  = w;
        e8_valid = 1'b1;
        tick();
        e8_data = 8'h00; // next word, taken at the PARITY edge
        vcnt = 0;
        for (int c = 0; c < 18; c++) begin
            if (e8_txv) vcnt++;
            if (c == 9) e8_valid = 1'b0;
            if (c == 8) begin
                check("b2b_par0", e8_tx, 1'b1);
                check("b2b_rdy0", {e8_last, e8_ready}, 2'b11);
            end else if (c == 17) begin
                check("b2b_par1", e8_tx, 1'b0);
                check("b2b_rdy1", {e8_last, e8_ready}, 2'b11);
            end else begin
                check($sformatf("b2b_bit%0d", c), e8_tx, (c < 8) ? w[c] : 1'b0);
                check($sformatf("b2b_nrdy%0d", c), e8_ready, 1'b0);
            end
            tick();
        end
        check("b2b_vcnt", vcnt, 32'd18);
        check("b2b_idle", e8_txv, 1'b0);
        check("b2b_cnt", e8_cnt, 16'd2);

        // ---- Reset during payload bit 3 of 0xFF ----
        do_reset();
        e8_data  = 8'hFF;
        e8_valid = 1'b1;
        tick();
        e8_valid = 1'b0;
        repeat (3) tick();
        check("abort_pre", {e8_txv, e8_tx}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("abort_txv", e8_txv, 1'b0);
        check("abort_cnt", e8_cnt, 16'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("abort_rdy", e8_ready, 1'b1);
        tick();
        check("abort_stay_idle", e8_txv, 1'b0);
        w = 8'h01;
        e8_data  = w;
        e8_valid = 1'b1;
        tick();
        e8_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("clean_bit%0d", i), e8_tx, w[i]);
            tick();
        end
        check("clean_par", {e8_txv, e8_last, e8_tx}, 3'b111);
        tick();
        check("clean_cnt", e8_cnt, 16'd1);

        // ---- DATA_W=1, CNT_W=2: words 1,0,1,1,0 back-to-back ----
        do_reset();
        e1_words = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        cnt_exp  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        e1_data  = e1_words[0];
        e1_valid = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("w1_data%0d", k), {e1_txv, e1_last, e1_tx}, {2'b10, e1_words[k]});
            tick();
            check($sformatf("w1_par%0d", k), {e1_txv, e1_last, e1_tx}, {2'b11, e1_words[k]});
            check($sformatf("w1_rdy%0d", k), e1_ready, 1'b1);
            if (k < 4) e1_data = e1_words[k+1];
            else       e1_valid = 1'b0;
            tick();
            check($sformatf("w1_cnt%0d", k), e1_cnt, cnt_exp[k]);
        end
        check("w1_idle", e1_txv, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
